// File: rtl/act_pkg.sv
// Shared widths and datapath types for the activation/requantization stage.
// ACT_ROUND_EN (in act_requant) selects round-half-up instead of truncation.
package act_pkg;

    localparam int IN_W    = 32;
    localparam int OUT_W   = 16;
    localparam int BIAS_W  = 16;
    localparam int SUM_W   = IN_W + 2;
    localparam int OUT_MAX = 2**(OUT_W-1) - 1;

    typedef logic signed [IN_W-1:0]   acc_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
    typedef logic signed [OUT_W-1:0]  pix_t;
    typedef logic signed [BIAS_W-1:0] bias_t;

endpackage

// File: rtl/act_sat_relu.sv
// Combinational ReLU + saturation of the shifted sum down to a 16-bit pixel.
module act_sat_relu
    import act_pkg::*;
(
    input  sum_t sum,
    output pix_t pix
);

    always_comb begin
        pix = '0;
        if (sum[SUM_W-1]) begin
            pix = '0;
        end else if (sum > sum_t'(OUT_MAX)) begin
            pix = pix_t'(OUT_MAX);
        end else begin
            pix = sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/act_requant.sv
// Bias add, arithmetic shift, saturate + ReLU; 3-cycle fixed-latency stream.
// Define ACT_ROUND_EN for round-half-up before the shift (default: truncation).
module act_requant
    import act_pkg::*;
#(
    parameter  int CH_NUM  = 16,
    parameter  int PIX_NUM = 576,
    parameter  int SHIFT_W = 5,
    localparam int CH_W    = (CH_NUM  > 1) ? $clog2(CH_NUM)  : 1,
    localparam int PIX_W   = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1
)(
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     frame_start,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     bias_we,
    input  logic [CH_W-1:0]          bias_addr,
    input  logic signed [BIAS_W-1:0] bias_data,
    input  logic signed [IN_W-1:0]   acc_in,
    input  logic                     valid_in,
    output logic [OUT_W-1:0]         data_out,
    output logic                     valid_out,
    output logic [CH_W-1:0]          ch_idx_out,
    output logic                     frame_done
);

    localparam int STAGES = 3;

    logic [STAGES:0] vld_pipe;
    bias_t           bias_tab [CH_NUM];
    logic [PIX_W-1:0] pix_cnt, cur_pix;
    logic [CH_W-1:0]  ch_cnt, cur_ch;
    logic             cur_last;
    sum_t             sum_in;

    sum_t             s1_sum, s2_pre, s2_val;
    logic [CH_W-1:0]  s1_ch, s2_ch;
    logic             s1_last, s2_last;
    pix_t             sat;

    assign vld_pipe[0] = valid_in;
    assign valid_out   = vld_pipe[STAGES];

    // frame_start makes the coincident sample pixel 0 / channel 0.
    always_comb begin
        cur_pix  = frame_start ? '0 : pix_cnt;
        cur_ch   = frame_start ? '0 : ch_cnt;
        cur_last = (cur_pix == PIX_W'(PIX_NUM-1)) && (cur_ch == CH_W'(CH_NUM-1));
        sum_in   = sum_t'(acc_in) + sum_t'(bias_tab[cur_ch]);
    end

    // Table is read above before this write lands, so a same-cycle hit sees the old value.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < CH_NUM; i++) bias_tab[i] <= '0;
        end else if (bias_we) begin
            bias_tab[bias_addr] <= bias_data;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else if (valid_in) begin
            if (cur_pix == PIX_W'(PIX_NUM-1)) begin
                pix_cnt <= '0;
                ch_cnt  <= (cur_ch == CH_W'(CH_NUM-1)) ? '0 : cur_ch + 1'b1;
            end else begin
                pix_cnt <= cur_pix + 1'b1;
                ch_cnt  <= cur_ch;
            end
        end else if (frame_start) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        end
    end

    // S1: bias add
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            s1_sum  <= '0;
            s1_ch   <= '0;
            s1_last <= 1'b0;
        end else if (vld_pipe[0]) begin
            s1_sum  <= sum_in;
            s1_ch   <= cur_ch;
            s1_last <= cur_last;
        end
    end

`ifdef ACT_ROUND_EN
    sum_t rnd;
    always_comb begin
        rnd = '0;
        if (cfg_shift != '0) rnd = sum_t'(1) <<< (cfg_shift - 1'b1);
    end
    assign s2_pre = s1_sum + rnd;
`else
    assign s2_pre = s1_sum;
`endif

    // S2: shift
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            s2_val  <= '0;
            s2_ch   <= '0;
            s2_last <= 1'b0;
        end else if (vld_pipe[1]) begin
            s2_val  <= s2_pre >>> cfg_shift;
            s2_ch   <= s1_ch;
            s2_last <= s1_last;
        end
    end

    act_sat_relu u_sat (
        .sum (s2_val),
        .pix (sat)
    );

    // S3: data and channel hold their last value across idle cycles.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            data_out   <= '0;
            ch_idx_out <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= vld_pipe[2] & s2_last;
            if (vld_pipe[2]) begin
                data_out   <= sat;
                ch_idx_out <= s2_ch;
            end
        end
    end

endmodule

// File: tb/tb_act_requant.sv
// Directed + randomized bench for act_requant against a cycle-free arithmetic model.
module tb_act_requant;

    localparam int CH_NUM  = 2;
    localparam int PIX_NUM = 4;
    localparam int SHIFT_W = 5;

    logic               clk = 1'b0;
    logic               Rst;
    logic               frame_start;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               bias_we;
    logic [0:0]         bias_addr;
    logic signed [15:0] bias_data;
    logic signed [31:0] acc_in;
    logic               valid_in;
    logic [15:0]        data_out;
    logic               valid_out;
    logic [0:0]         ch_idx_out;
    logic               frame_done;

    act_requant #(.CH_NUM(CH_NUM), .PIX_NUM(PIX_NUM), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .Rst(Rst), .frame_start(frame_start), .cfg_shift(cfg_shift),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .acc_in(acc_in), .valid_in(valid_in), .data_out(data_out),
        .valid_out(valid_out), .ch_idx_out(ch_idx_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int d; int ch; bit fd; } exp_t;

    exp_t pipe[$];
    int   bias_m [CH_NUM];
    int   pix_m, ch_m, last_d;
    int   errors = 0, checks = 0;

`ifdef ACT_ROUND_EN
    localparam int ROUND_EXP = 7;
`else
    localparam int ROUND_EXP = 6;
`endif

    function automatic int ref_val(int acc, int b, int sh);
        longint s;
        s = longint'(acc) + longint'(b);
`ifdef ACT_ROUND_EN
        if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
        s = s >>> sh;
        if (s < 0) return 0;
        if (s > 32767) return 32767;
        return int'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        e = '{v: 1'b0, d: 0, ch: 0, fd: 1'b0};
        pipe.delete();
        pipe.push_back(e);
        pipe.push_back(e);
        for (int i = 0; i < CH_NUM; i++) bias_m[i] = 0;
        pix_m  = 0;
        ch_m   = 0;
        last_d = 0;
    endtask

    // One clock: model the sample on the current inputs, then compare outputs.
    task automatic tick();
        exp_t e;
        int   cp, cc;
        e = '{v: 1'b0, d: 0, ch: 0, fd: 1'b0};
        if (valid_in) begin
            cp = frame_start ? 0 : pix_m;
            cc = frame_start ? 0 : ch_m;
            e.v  = 1'b1;
            e.d  = ref_val(int'(acc_in), bias_m[cc], int'(cfg_shift));
            e.ch = cc;
            e.fd = (cp == PIX_NUM-1) && (cc == CH_NUM-1);
            cp++;
            if (cp == PIX_NUM) begin
                cp = 0;
                cc = (cc + 1) % CH_NUM;
            end
            pix_m = cp;
            ch_m  = cc;
        end else if (frame_start) begin
            pix_m = 0;
            ch_m  = 0;
        end
        if (bias_we) bias_m[int'(bias_addr)] = int'(bias_data);
        pipe.push_back(e);
        @(posedge clk);
        #1;
        e = pipe.pop_front();
        if (e.v) last_d = e.d;
        chk("valid_out", 32'(valid_out), 32'(e.v));
        chk("data_out", 32'(data_out), last_d);
        if (e.v) chk("ch_idx_out", 32'(ch_idx_out), e.ch);
        chk("frame_done", 32'(frame_done), 32'(e.fd));
    endtask

    task automatic cyc(input bit v, input logic [31:0] a, input bit fs,
                       input bit we, input int addr, input int bd);
        valid_in    = v;
        acc_in      = a;
        frame_start = fs;
        bias_we     = we;
        bias_addr   = 1'(addr);
        bias_data   = 16'(bd);
        tick();
        valid_in    = 1'b0;
        frame_start = 1'b0;
        bias_we     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wbias(input int addr, input int bd);
        cyc(0, 0, 0, 1, addr, bd);
    endtask

    initial begin
        Rst = 1'b1; frame_start = 0; cfg_shift = 0; bias_we = 0;
        bias_addr = 0; bias_data = 0; acc_in = 0; valid_in = 0;
        #1;
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_ch_idx_out", 32'(ch_idx_out), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        @(posedge clk); #1;
        Rst = 1'b0;
        model_reset();

        // rounding: (100 + 4) >> 4
        wbias(0, 4);
        cfg_shift = 4;
        cyc(1, 100, 1, 0, 0, 0);
        idle(2);
        chk("round_value", 32'(data_out), ROUND_EXP);
        chk("round_latency", 32'(valid_out), 1);
        idle(2);

        // ReLU
        wbias(0, 0);
        cfg_shift = 0;
        cyc(1, -500, 1, 0, 0, 0);
        idle(3);

        // saturation
        wbias(0, 32'h7FFF);
        cyc(1, 32'h7FFF_FFFF, 1, 0, 0, 0);
        cyc(1, 40000, 0, 0, 0, 0);
        idle(3);

        // channel sweep, contiguous then with gaps
        wbias(0, 0);
        wbias(1, 100);
        for (int i = 0; i < 8; i++) cyc(1, 0, i == 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, i == 0, 0, 0, 0);
            if (i == 2 || i == 5) idle(2);
        end
        idle(3);

        // frame_start coinciding with pixel 2
        cyc(1, 7, 1, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0);
        cyc(1, 7, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 9, 0, 0, 0, 0);
        // now at ch1 pix0: same-cycle write to ch1
        cyc(1, 10, 0, 1, 1, 500);
        cyc(1, 10, 0, 0, 0, 0);
        idle(3);

        // randomized blocks; shift changes only with the pipeline drained
        for (int blk = 0; blk < 6; blk++) begin
            cfg_shift = SHIFT_W'($urandom_range(0, 31));
            for (int i = 0; i < 50; i++) begin
                cyc($urandom_range(0, 9) < 7,
                    ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 200000) - 100000,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, CH_NUM-1)),
                    int'($urandom));
            end
            idle(3);
        end

        // reset with three samples in flight
        cfg_shift = 0;
        wbias(0, 50);
        cyc(1, 1000, 1, 0, 0, 0);
        cyc(1, 1001, 0, 0, 0, 0);
        valid_in = 1'b1; acc_in = 1002;
        @(posedge clk); #1;
        valid_in = 1'b0;
        Rst = 1'b1;
        #1;
        chk("midrst_valid_out", 32'(valid_out), 0);
        chk("midrst_data_out", 32'(data_out), 0);
        chk("midrst_frame_done", 32'(frame_done), 0);
        @(posedge clk); #1;
        Rst = 1'b0;
        model_reset();
        cyc(1, 1234, 0, 0, 0, 0);
        idle(2);
        chk("postrst_value", 32'(data_out), 1234);
        chk("postrst_ch", 32'(ch_idx_out), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
